clock_set_controller: RTL and testbench

- Sequences the seconds, minutes and hours DualBCDCounter instances of the digital clock.
- RUN mode: generates the 1 Hz seconds tick and ripples carries into minutes and hours.
- SET modes: steers debounced button presses, with auto-repeat, to a single selected field, suppresses carry ripple and drives blink/select indication for the display.

---
 rtl/clock_ctrl_pkg.sv | 22 ++
 rtl/button_conditioner.sv | 66 ++++++
 rtl/clock_set_controller.sv | 154 +++++++++++++++
 tb/tb_clock_set_controller.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_ctrl_pkg.sv
// Shared state and field-select encodings for the clock set controller.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2
    } state_t;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HR   = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;

    function automatic logic [1:0] field_of(input state_t st);
        case (st)
            ST_SET_HR:  return FIELD_HR;
            ST_SET_MIN: return FIELD_MIN;
            default:    return FIELD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// Synchronizes one debounced button, emits a pulse on each press and,
// optionally, auto-repeat pulses while the button stays held.
module button_conditioner
    import clock_ctrl_pkg::*;
#(
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000,
    parameter bit REPEAT_EN     = 1'b1
) (
    input  logic clk_i,
    input  logic nreset_i,
    input  logic btn_i,
    input  logic clear_i,
    output logic level_o,
    output logic pulse_o
);

    localparam int MAX_LOAD = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CW       = $clog2(MAX_LOAD);
    localparam logic [CW-1:0] HOLD_LOAD   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REPEAT_LOAD = CW'(REPEAT_CYCLES - 1);

    logic          sync1_q, sync2_q, prev_q;
    logic          active_d, active_q;
    logic [CW-1:0] cnt_d, cnt_q;
    logic          rise, rep;

    assign rise    = sync2_q & ~prev_q;
    assign rep     = REPEAT_EN && active_q && (cnt_q == '0) && sync2_q;
    assign level_o = sync2_q;
    assign pulse_o = ~clear_i & (rise | rep);

    // Down-counter is only meaningful while active_q; a release or clear drops it at once.
    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        if (!REPEAT_EN || clear_i || !sync2_q) begin
            active_d = 1'b0;
            cnt_d    = '0;
        end else if (rise) begin
            active_d = 1'b1;
            cnt_d    = HOLD_LOAD;
        end else if (rep) begin
            cnt_d    = REPEAT_LOAD;
        end else if (active_q) begin
            cnt_d    = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            active_q <= active_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/clock_set_controller.sv
// Sequences the seconds/minutes/hours counters: 1 Hz tick and carry ripple in
// RUN, button-driven single-field adjustment with blink in the SET modes.
//
// state      | meaning
// ST_RUN     | seconds tick runs, carries ripple sec -> min -> hr
// ST_SET_HR  | up/down buttons step the hours field
// ST_SET_MIN | up/down buttons step the minutes field; leaving clears seconds
module clock_set_controller
    import clock_ctrl_pkg::*;
#(
    parameter int CLK_DIV       = 50000000,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000,
    parameter int BLINK_DIV     = 12500000
) (
    input  logic       clk_i,
    input  logic       nreset_i,
    input  logic       mode_btn_i,
    input  logic       up_btn_i,
    input  logic       down_btn_i,
    input  logic       sec_carryup_i,
    input  logic       min_carryup_i,
    output logic       sec_up_o,
    output logic       sec_nreset_o,
    output logic       min_up_o,
    output logic       min_down_o,
    output logic       hr_up_o,
    output logic       hr_down_o,
    output logic [1:0] field_sel_o,
    output logic       blink_o
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_DIV - 1);

    state_t        state_d, state_q;
    logic [PW-1:0] presc_d, presc_q;
    logic [BW-1:0] blink_cnt_d, blink_cnt_q;
    logic          sec_up_d, sec_up_q, sec_nreset_d, sec_nreset_q;
    logic          min_up_d, min_up_q, min_down_d, min_down_q;
    logic          hr_up_d, hr_up_q, hr_down_d, hr_down_q;
    logic [1:0]    field_d, field_q;
    logic          blink_d, blink_q;

    logic mode_evt, mode_lvl_unused;
    logic up_pulse, up_lvl, dn_pulse, dn_lvl;
    logic ud_clear, tick;

    // Up/down are dead in RUN, cancel each other when both held, and lose to a mode event.
    assign ud_clear = mode_evt | (up_lvl & dn_lvl) | (state_q == ST_RUN);

    button_conditioner #(
        .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b0)
    ) u_mode (
        .clk_i(clk_i), .nreset_i(nreset_i), .btn_i(mode_btn_i), .clear_i(1'b0),
        .level_o(mode_lvl_unused), .pulse_o(mode_evt)
    );

    button_conditioner #(
        .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b1)
    ) u_up (
        .clk_i(clk_i), .nreset_i(nreset_i), .btn_i(up_btn_i), .clear_i(ud_clear),
        .level_o(up_lvl), .pulse_o(up_pulse)
    );

    button_conditioner #(
        .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b1)
    ) u_down (
        .clk_i(clk_i), .nreset_i(nreset_i), .btn_i(down_btn_i), .clear_i(ud_clear),
        .level_o(dn_lvl), .pulse_o(dn_pulse)
    );

    assign tick = (state_q == ST_RUN) && (presc_q == PRESC_MAX);

    always_comb begin
        state_d = state_q;
        if (mode_evt) begin
            case (state_q)
                ST_RUN:    state_d = ST_SET_HR;
                ST_SET_HR: state_d = ST_SET_MIN;
                default:   state_d = ST_RUN;
            endcase
        end

        if (state_q == ST_RUN && state_d == ST_RUN)
            presc_d = tick ? '0 : presc_q + 1'b1;
        else
            presc_d = '0;

        sec_up_d     = tick && !mode_evt;
        sec_nreset_d = !(state_q == ST_SET_MIN && mode_evt);
        hr_up_d      = (state_q == ST_SET_HR)  && !mode_evt && up_pulse;
        hr_down_d    = (state_q == ST_SET_HR)  && !mode_evt && dn_pulse;
        min_up_d     = (state_q == ST_SET_MIN) && !mode_evt && up_pulse;
        min_down_d   = (state_q == ST_SET_MIN) && !mode_evt && dn_pulse;
        field_d      = field_of(state_d);

        // Blink restarts high on every entry into a SET state.
        if (state_d == ST_RUN) begin
            blink_d     = 1'b0;
            blink_cnt_d = '0;
        end else if (state_d != state_q) begin
            blink_d     = 1'b1;
            blink_cnt_d = BLINK_LOAD;
        end else if (blink_cnt_q == '0) begin
            blink_d     = ~blink_q;
            blink_cnt_d = BLINK_LOAD;
        end else begin
            blink_d     = blink_q;
            blink_cnt_d = blink_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q      <= ST_RUN;
            presc_q      <= '0;
            sec_up_q     <= 1'b0;
            sec_nreset_q <= 1'b1;
            min_up_q     <= 1'b0;
            min_down_q   <= 1'b0;
            hr_up_q      <= 1'b0;
            hr_down_q    <= 1'b0;
            field_q      <= FIELD_NONE;
            blink_q      <= 1'b0;
            blink_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            sec_up_q     <= sec_up_d;
            sec_nreset_q <= sec_nreset_d;
            min_up_q     <= min_up_d;
            min_down_q   <= min_down_d;
            hr_up_q      <= hr_up_d;
            hr_down_q    <= hr_down_d;
            field_q      <= field_d;
            blink_q      <= blink_d;
            blink_cnt_q  <= blink_cnt_d;
        end
    end

    // In RUN the counter carries pass straight through; elsewhere only button pulses drive up.
    assign sec_up_o     = sec_up_q;
    assign sec_nreset_o = sec_nreset_q;
    assign min_up_o     = (state_q == ST_RUN) ? sec_carryup_i : min_up_q;
    assign hr_up_o      = (state_q == ST_RUN) ? min_carryup_i : hr_up_q;
    assign min_down_o   = min_down_q;
    assign hr_down_o    = hr_down_q;
    assign field_sel_o  = field_q;
    assign blink_o      = blink_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller with a 23:59:59 counter model.
module tb_clock_set_controller;

    localparam int CLK_DIV = 4;
    localparam int HOLD    = 8;
    localparam int REP     = 3;
    localparam int BLINK   = 2;

    logic clk = 1'b0, nreset = 1'b0;
    logic mode_btn = 1'b0, up_btn = 1'b0, down_btn = 1'b0;
    logic sec_carry, min_carry;
    logic sec_up_o, sec_nreset_o, min_up_o, min_down_o, hr_up_o, hr_down_o, blink_o;
    logic [1:0] field_sel_o;
    logic [8:0] obs;

    int sec_m, min_m, hr_m;
    logic load_req = 1'b0;
    int ld_h = 0, ld_m = 0, ld_s = 0;
    int total = 0, bad = 0;

    typedef struct {
        logic       mode;
        logic       up;
        logic       dn;
        logic [8:0] exp;
    } vec_t;
    vec_t vecs[22];

    clock_set_controller #(
        .CLK_DIV(CLK_DIV), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .BLINK_DIV(BLINK)
    ) dut (
        .clk_i(clk), .nreset_i(nreset), .mode_btn_i(mode_btn), .up_btn_i(up_btn),
        .down_btn_i(down_btn), .sec_carryup_i(sec_carry), .min_carryup_i(min_carry),
        .sec_up_o(sec_up_o), .sec_nreset_o(sec_nreset_o), .min_up_o(min_up_o),
        .min_down_o(min_down_o), .hr_up_o(hr_up_o), .hr_down_o(hr_down_o),
        .field_sel_o(field_sel_o), .blink_o(blink_o)
    );

    always #5 clk = ~clk;

    assign obs       = {sec_up_o, sec_nreset_o, min_up_o, min_down_o, hr_up_o, hr_down_o, field_sel_o, blink_o};
    assign sec_carry = sec_up_o && (sec_m == 59);
    assign min_carry = min_up_o && (min_m == 59);

    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sec_m <= 0; min_m <= 0; hr_m <= 0;
        end else if (load_req) begin
            sec_m <= ld_s; min_m <= ld_m; hr_m <= ld_h;
        end else begin
            if (!sec_nreset_o)  sec_m <= 0;
            else if (sec_up_o)  sec_m <= (sec_m == 59) ? 0 : sec_m + 1;
            if (min_up_o)        min_m <= (min_m == 59) ? 0 : min_m + 1;
            else if (min_down_o) min_m <= (min_m == 0) ? 59 : min_m - 1;
            if (hr_up_o)         hr_m <= (hr_m == 23) ? 0 : hr_m + 1;
            else if (hr_down_o)  hr_m <= (hr_m == 0) ? 23 : hr_m - 1;
        end
    end

    function automatic vec_t mk(logic m, logic u, logic d, logic su, logic hu, logic [1:0] f, logic b);
        vec_t v;
        v.mode = m; v.up = u; v.dn = d;
        v.exp  = {su, 1'b1, 1'b0, 1'b0, hu, 1'b0, f, b};
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic preload(input int h, input int m, input int s);
        ld_h = h; ld_m = m; ld_s = s;
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic mode_press();
        mode_btn = 1'b1;
        tick();
        mode_btn = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int n, first, cnt, k;
        int t[$];

        // cycle numbers count posedges after reset release
        vecs[0]  = mk(0,0,0, 0,0, 2'd0,0);
        vecs[1]  = mk(0,0,0, 0,0, 2'd0,0);
        vecs[2]  = mk(0,0,0, 0,0, 2'd0,0);
        vecs[3]  = mk(0,0,0, 1,0, 2'd0,0);
        vecs[4]  = mk(0,0,0, 0,0, 2'd0,0);
        vecs[5]  = mk(0,0,0, 0,0, 2'd0,0);
        vecs[6]  = mk(0,0,0, 0,0, 2'd0,0);
        vecs[7]  = mk(0,0,0, 1,0, 2'd0,0);
        vecs[8]  = mk(0,0,0, 0,0, 2'd0,0);
        vecs[9]  = mk(0,0,0, 0,0, 2'd0,0);
        vecs[10] = mk(0,0,0, 0,0, 2'd0,0);
        vecs[11] = mk(0,0,0, 1,0, 2'd0,0);
        vecs[12] = mk(1,0,0, 0,0, 2'd0,0);
        vecs[13] = mk(0,0,0, 0,0, 2'd0,0);
        vecs[14] = mk(0,0,0, 0,0, 2'd1,1);
        vecs[15] = mk(0,0,0, 0,0, 2'd1,1);
        vecs[16] = mk(0,1,0, 0,0, 2'd1,0);
        vecs[17] = mk(0,0,0, 0,0, 2'd1,0);
        vecs[18] = mk(0,0,0, 0,1, 2'd1,1);
        vecs[19] = mk(0,0,0, 0,0, 2'd1,1);
        vecs[20] = mk(0,0,0, 0,0, 2'd1,0);
        vecs[21] = mk(0,0,0, 0,0, 2'd1,0);

        @(negedge clk);
        check("reset_outputs", int'(obs), int'(9'b010000000));
        nreset = 1'b1;

        for (int i = 0; i < 22; i++) begin
            mode_btn = vecs[i].mode;
            up_btn   = vecs[i].up;
            down_btn = vecs[i].dn;
            tick();
            if (obs !== vecs[i].exp) begin
                bad++;
                $display("FAIL vec_cycle%0d: got %b expected %b", i + 1, obs, vecs[i].exp);
            end
            total++;
        end
        mode_btn = 1'b0; up_btn = 1'b0; down_btn = 1'b0;
        check("time_after_table", hr_m * 10000 + min_m * 100 + sec_m, 10003);

        // SET_HR: single up press wraps 23 -> 00
        preload(23, 0, 3);
        up_btn = 1'b1;
        tick();
        up_btn = 1'b0;
        n = 0; first = -1; cnt = 0;
        for (int j = 1; j <= 8; j++) begin
            tick();
            if (hr_up_o) begin n++; if (first < 0) first = j; end
            if (sec_up_o || min_up_o || min_down_o || hr_down_o) cnt++;
        end
        check("hr_up_count", n, 1);
        check("hr_up_latency", first, 2);
        check("set_hr_other_pulses", cnt, 0);
        check("hr_wrap_time", hr_m * 10000 + min_m * 100 + sec_m, 3);

        // SET_MIN: hold down 20 cycles for auto-repeat
        mode_press();
        check("field_set_min", int'(field_sel_o), 2);
        cnt = 0;
        for (int j = 1; j <= 30; j++) begin
            down_btn = (j <= 20);
            tick();
            if (min_down_o) t.push_back(j);
            if (min_up_o || hr_up_o || hr_down_o) cnt++;
        end
        down_btn = 1'b0;
        check("min_down_count", t.size(), 5);
        if (t.size() == 5) begin
            check("rep_off1", t[1] - t[0], 8);
            check("rep_off2", t[2] - t[0], 11);
            check("rep_off3", t[3] - t[0], 14);
            check("rep_off4", t[4] - t[0], 17);
        end
        check("set_min_other_pulses", cnt, 0);
        check("min_wrap_time", hr_m * 10000 + min_m * 100 + sec_m, 5503);

        // up and down together: cancelled
        cnt = 0;
        for (int j = 1; j <= 13; j++) begin
            up_btn   = (j <= 10);
            down_btn = (j <= 10);
            tick();
            if (min_up_o || min_down_o || hr_up_o || hr_down_o) cnt++;
        end
        check("both_pressed_pulses", cnt, 0);

        // leave SET_MIN: one-cycle seconds clear, then full tick period
        mode_btn = 1'b1;
        tick();
        mode_btn = 1'b0;
        first = -1;
        for (int j = 1; j <= 10 && first < 0; j++) begin
            tick();
            if (!sec_nreset_o) first = j;
        end
        check("sec_nreset_seen", (first > 0) ? 1 : 0, 1);
        check("field_run", int'(field_sel_o), 0);
        check("blink_run", int'(blink_o), 0);
        k = -1;
        for (int j = 1; j <= 10 && k < 0; j++) begin
            tick();
            if (j == 1) begin
                check("sec_nreset_one_cycle", int'(sec_nreset_o), 1);
                check("sec_cleared", sec_m, 0);
            end
            if (sec_up_o) k = j;
        end
        check("tick_after_run_entry", k, 4);

        // RUN: full carry ripple 00:59:59 -> 01:00:00
        preload(0, 59, 59);
        k = -1;
        for (int j = 1; j <= 8 && k < 0; j++) begin
            tick();
            if (sec_up_o) k = j;
        end
        check("ripple_tick_seen", (k > 0) ? 1 : 0, 1);
        check("ripple_min_up", int'(min_up_o), 1);
        check("ripple_hr_up", int'(hr_up_o), 1);
        check("ripple_downs", int'({min_down_o, hr_down_o}), 0);
        tick();
        check("ripple_time", hr_m * 10000 + min_m * 100 + sec_m, 10000);

        // SET_HR with up held, then reset mid-repeat
        mode_press();
        check("field_set_hr", int'(field_sel_o), 1);
        up_btn = 1'b1;
        n = 0;
        for (int j = 1; j <= 12; j++) begin
            tick();
            if (hr_up_o) n++;
        end
        check("hr_repeat_before_reset", n, 2);
        nreset = 1'b0;
        #1;
        check("midrun_reset_outputs", int'(obs), int'(9'b010000000));
        @(negedge clk);
        up_btn = 1'b0;
        @(negedge clk);
        nreset = 1'b1;
        k = -1; cnt = 0;
        for (int j = 1; j <= 8 && k < 0; j++) begin
            tick();
            if (sec_up_o) k = j;
            if (field_sel_o != 2'd0 || hr_up_o || hr_down_o) cnt++;
        end
        check("post_reset_tick", k, 4);
        check("post_reset_run", cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
